// File: rtl/bram_bist_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bram_bist_pkg : shared FSM states, pattern generator and latency bounds
// Rev 1.0
// ---------------------------------------------------------------------------
package bram_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR0  = 3'd1,
        S_RD0  = 3'd2,
        S_DRN0 = 3'd3,
        S_WR1  = 3'd4,
        S_RD1  = 3'd5,
        S_DRN1 = 3'd6,
        S_FIN  = 3'd7
    } bist_state_t;

    localparam int c_MAX_DATA_WIDTH   = 36;
    localparam int c_MIN_READ_LATENCY = 1;
    localparam int c_MAX_READ_LATENCY = 2;

    // Only the low 36 bits of the wide result are ever used, so the OR/shift
    // can be done directly at 36 bits without changing the truncated value.
    function automatic logic [c_MAX_DATA_WIDTH-1:0] bist_pattern(input logic [31:0] addr);
        logic [c_MAX_DATA_WIDTH-1:0] w_a;
        w_a = {4'd0, addr};
        return w_a | (w_a << 20) | 36'h0_0005_5000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_bist_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bram_bist_checker : read-latency pipeline, comparator, error count/capture
// Rev 1.0
// ---------------------------------------------------------------------------
module bram_bist_checker #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 36,
    parameter int READ_LATENCY  = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_exp,
    input  logic [ADDR_WIDTH-1:0]    in_addr,
    input  logic [DATA_WIDTH-1:0]    rq,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic                     first_err_valid,
    output logic [ADDR_WIDTH-1:0]    first_err_addr,
    output logic                     err_now
);

    logic [READ_LATENCY-1:0] r_vld;
    logic [DATA_WIDTH-1:0]   r_exp  [READ_LATENCY];
    logic [ADDR_WIDTH-1:0]   r_addr [READ_LATENCY];

    assign err_now = r_vld[READ_LATENCY-1] && (rq !== r_exp[READ_LATENCY-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld           <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_exp[i]  <= '0;
                r_addr[i] <= '0;
            end
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else begin
            r_vld[0]  <= in_valid;
            r_exp[0]  <= in_exp;
            r_addr[0] <= in_addr;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_exp[i]  <= r_exp[i-1];
                r_addr[i] <= r_addr[i-1];
            end
            if (clear) begin
                err_cnt         <= '0;
                first_err_valid <= 1'b0;
                first_err_addr  <= '0;
            end else if (err_now) begin
                if (err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= r_addr[READ_LATENCY-1];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_sdp_bist.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bram_sdp_bist : march-style BIST engine for simple-dual-port block RAM
// Rev 1.0
// ---------------------------------------------------------------------------
module bram_sdp_bist
    import bram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 36,
    parameter int READ_LATENCY  = 1,
    parameter int ADDR_INCR     = 1,
    parameter int INVERT_PASS   = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic                     first_err_valid,
    output logic [ADDR_WIDTH-1:0]    first_err_addr,
    output logic                     mem_wce,
    output logic [ADDR_WIDTH-1:0]    mem_wa,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    output logic                     mem_rce,
    output logic [ADDR_WIDTH-1:0]    mem_ra,
    input  logic [DATA_WIDTH-1:0]    mem_rq
);

    localparam int c_DEPTH = 2**ADDR_WIDTH;

    bist_state_t                 r_state;
    logic [ADDR_WIDTH:0]         r_addr;
    logic [1:0]                  r_drn_cnt;
    logic [DATA_WIDTH-1:0]       r_rd_exp;

    logic [31:0]                 w_addr_next;
    logic                        w_last;
    logic [c_MAX_DATA_WIDTH-1:0] w_pat_full;
    logic [DATA_WIDTH-1:0]       w_exp;
    logic                        w_inv;
    logic                        w_clear;
    logic                        w_err_now;

    assign w_addr_next = 32'(r_addr) + 32'(ADDR_INCR);
    assign w_last      = (w_addr_next >= 32'(c_DEPTH));
    assign w_pat_full  = bist_pattern(32'(r_addr));
    assign w_inv       = (r_state == S_WR1) || (r_state == S_RD1);
    assign w_exp       = w_inv ? ~w_pat_full[DATA_WIDTH-1:0] : w_pat_full[DATA_WIDTH-1:0];
    assign w_clear     = (r_state == S_IDLE) && start;

    // Memory strobes follow the state by one cycle; the read-check pipeline is
    // fed from the registered read strobe so it lines up with the RAM latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_drn_cnt <= '0;
            r_rd_exp  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            mem_wce   <= 1'b0;
            mem_wa    <= '0;
            mem_wd    <= '0;
            mem_rce   <= 1'b0;
            mem_ra    <= '0;
        end else begin
            done    <= 1'b0;
            mem_wce <= 1'b0;
            mem_rce <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_WR0;
                        r_addr  <= '0;
                        busy    <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                S_WR0, S_WR1: begin
                    mem_wce <= 1'b1;
                    mem_wa  <= r_addr[ADDR_WIDTH-1:0];
                    mem_wd  <= w_exp;
                    if (w_last) begin
                        r_addr  <= '0;
                        r_state <= (r_state == S_WR0) ? S_RD0 : S_RD1;
                    end else begin
                        r_addr  <= w_addr_next[ADDR_WIDTH:0];
                    end
                end
                S_RD0, S_RD1: begin
                    mem_rce  <= 1'b1;
                    mem_ra   <= r_addr[ADDR_WIDTH-1:0];
                    r_rd_exp <= w_exp;
                    if (w_last) begin
                        r_addr    <= '0;
                        r_drn_cnt <= '0;
                        r_state   <= (r_state == S_RD0) ? S_DRN0 : S_DRN1;
                    end else begin
                        r_addr    <= w_addr_next[ADDR_WIDTH:0];
                    end
                end
                S_DRN0, S_DRN1: begin
                    if (r_drn_cnt == 2'(READ_LATENCY - 1)) begin
                        r_addr  <= '0;
                        r_state <= (r_state == S_DRN0 && INVERT_PASS != 0) ? S_WR1 : S_FIN;
                    end else begin
                        r_drn_cnt <= r_drn_cnt + 2'd1;
                    end
                end
                S_FIN: begin
                    // The final in-flight compare resolves on this same edge.
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    pass    <= (err_cnt == '0) && !w_err_now;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    bram_bist_checker #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .READ_LATENCY  (READ_LATENCY),
        .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_checker (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (w_clear),
        .in_valid        (mem_rce),
        .in_exp          (r_rd_exp),
        .in_addr         (mem_ra),
        .rq              (mem_rq),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr),
        .err_now         (w_err_now)
    );

endmodule
`default_nettype wire

// File: tb/tb_bram_sdp_bist.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bram_sdp_bist : two BIST instances against behavioural RAM models
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_bram_sdp_bist;

    logic clk;
    logic rst_n;

    // Instance A: 16x36, RL=1, inverted pass. Instance B: 16x8, RL=2, step 3.
    logic        a_start, a_busy, a_done, a_pass, a_fev, a_wce, a_rce;
    logic [15:0] a_err;
    logic [3:0]  a_fea, a_wa, a_ra;
    logic [35:0] a_wd, a_rq;

    logic        b_start, b_busy, b_done, b_pass, b_fev, b_wce, b_rce;
    logic [1:0]  b_err;
    logic [3:0]  b_fea, b_wa, b_ra;
    logic [7:0]  b_wd, b_rq, b_q1, b_q2;

    logic        fault_a, zero_b;
    logic [35:0] ram_a [16];
    logic [7:0]  ram_b [16];

    typedef struct {
        int          addr;
        logic [35:0] data;
    } wr_t;

    wr_t  qa_w[$], qb_w[$];
    int   qa_r[$], qb_r[$];
    wr_t  mon_a_w, mon_b_w;
    int   mon_a_r, mon_b_r;
    int   checks, errors;
    int   a_done_cnt;
    logic [35:0] a_wd5;
    bit   a_seen5;

    bram_sdp_bist #(
        .ADDR_WIDTH(4), .DATA_WIDTH(36), .READ_LATENCY(1),
        .ADDR_INCR(1), .INVERT_PASS(1), .ERR_CNT_WIDTH(16)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
        .pass(a_pass), .err_cnt(a_err), .first_err_valid(a_fev),
        .first_err_addr(a_fea), .mem_wce(a_wce), .mem_wa(a_wa), .mem_wd(a_wd),
        .mem_rce(a_rce), .mem_ra(a_ra), .mem_rq(a_rq)
    );

    bram_sdp_bist #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(2),
        .ADDR_INCR(3), .INVERT_PASS(0), .ERR_CNT_WIDTH(2)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
        .pass(b_pass), .err_cnt(b_err), .first_err_valid(b_fev),
        .first_err_addr(b_fea), .mem_wce(b_wce), .mem_wa(b_wa), .mem_wd(b_wd),
        .mem_rce(b_rce), .mem_ra(b_ra), .mem_rq(b_rq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM models; A can force bit0 of address 5 low, B can return all zeros.
    always @(posedge clk) begin
        if (a_wce) ram_a[a_wa] <= a_wd;
        if (a_rce) begin
            a_rq <= ram_a[a_ra];
            if (fault_a && a_ra == 4'd5) a_rq[0] <= 1'b0;
        end
        if (b_wce) ram_b[b_wa] <= b_wd;
        if (b_rce) b_q1 <= ram_b[b_ra];
        b_q2 <= b_q1;
    end
    assign b_rq = zero_b ? 8'd0 : b_q2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop one expected write/read per strobe seen on the RAM ports.
    always @(negedge clk) begin
        if (a_done) a_done_cnt++;
        if (a_wce) begin
            if (a_wa == 4'd5 && !a_seen5) begin
                a_wd5   = a_wd;
                a_seen5 = 1'b1;
            end
            if (qa_w.size() == 0) chk("a_wr_extra", 1, 0);
            else begin
                mon_a_w = qa_w.pop_front();
                chk("a_wa", 64'(a_wa), 64'(mon_a_w.addr));
                chk("a_wd", 64'(a_wd), 64'(mon_a_w.data));
            end
        end
        if (a_rce) begin
            if (qa_r.size() == 0) chk("a_rd_extra", 1, 0);
            else begin
                mon_a_r = qa_r.pop_front();
                chk("a_ra", 64'(a_ra), 64'(mon_a_r));
            end
        end
        if (b_wce) begin
            if (qb_w.size() == 0) chk("b_wr_extra", 1, 0);
            else begin
                mon_b_w = qb_w.pop_front();
                chk("b_wa", 64'(b_wa), 64'(mon_b_w.addr));
                chk("b_wd", 64'(b_wd), 64'(mon_b_w.data));
            end
        end
        if (b_rce) begin
            if (qb_r.size() == 0) chk("b_rd_extra", 1, 0);
            else begin
                mon_b_r = qb_r.pop_front();
                chk("b_ra", 64'(b_ra), 64'(mon_b_r));
            end
        end
    end

    task automatic push_a();
        logic [35:0] pv;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 16; a++) begin
                pv = bram_bist_pkg::bist_pattern(32'(a));
                qa_w.push_back('{addr: a, data: (p != 0) ? ~pv : pv});
            end
            for (int a = 0; a < 16; a++) qa_r.push_back(a);
        end
    endtask

    task automatic push_b();
        logic [35:0] pv;
        for (int a = 0; a < 16; a += 3) begin
            pv = bram_bist_pkg::bist_pattern(32'(a)) & 36'hFF;
            qb_w.push_back('{addr: a, data: pv});
            qb_r.push_back(a);
        end
    endtask

    task automatic run_bist(input int which, input int exp_len);
        int k;
        bit seen;
        @(negedge clk);
        if (which == 0) a_start = 1'b1; else b_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        b_start = 1'b0;
        chk("busy_start", 64'((which == 0) ? a_busy : b_busy), 1);
        k = 0;
        seen = 1'b0;
        while (!seen && k < exp_len + 40) begin
            @(posedge clk); #1;
            k++;
            if (((which == 0) ? a_done : b_done) == 1'b1) seen = 1'b1;
        end
        chk("run_len", seen ? 64'(k) : '1, 64'(exp_len));
        @(posedge clk); #1;
        chk("done_pulse", 64'((which == 0) ? a_done : b_done), 0);
        chk("busy_end", 64'((which == 0) ? a_busy : b_busy), 0);
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_busy"}, 64'(a_busy), 0);
        chk({tag, "_done"}, 64'(a_done), 0);
        chk({tag, "_pass"}, 64'(a_pass), 0);
        chk({tag, "_err"},  64'(a_err), 0);
        chk({tag, "_fev"},  64'(a_fev), 0);
        chk({tag, "_fea"},  64'(a_fea), 0);
        chk({tag, "_wce"},  64'(a_wce), 0);
        chk({tag, "_wa"},   64'(a_wa), 0);
        chk({tag, "_wd"},   64'(a_wd), 0);
        chk({tag, "_rce"},  64'(a_rce), 0);
        chk({tag, "_ra"},   64'(a_ra), 0);
    endtask

    initial begin
        checks = 0; errors = 0; a_done_cnt = 0; a_seen5 = 1'b0; a_wd5 = '0;
        rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0;
        fault_a = 1'b0; zero_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_a_reset("rst");
        chk("rst_b_busy", 64'(b_busy), 0);
        chk("rst_b_err",  64'(b_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ideal RAM, true + inverted pass
        push_a();
        run_bist(0, 67);
        chk("a_ok_pass", 64'(a_pass), 1);
        chk("a_ok_err",  64'(a_err), 0);
        chk("a_ok_fev",  64'(a_fev), 0);
        chk("a_wd_addr5", 64'(a_wd5), 64'h0_0055_5005);
        chk("a_ok_qdrain", 64'(qa_w.size() + qa_r.size()), 0);

        // Bit0 stuck low at address 5: only the true pass reads a 1 there
        fault_a = 1'b1;
        push_a();
        run_bist(0, 67);
        fault_a = 1'b0;
        chk("a_flt_pass", 64'(a_pass), 0);
        chk("a_flt_err",  64'(a_err), 1);
        chk("a_flt_fev",  64'(a_fev), 1);
        chk("a_flt_fea",  64'(a_fea), 5);

        // RL=2, step 3: N=6, length 2*6+2+1
        push_b();
        run_bist(1, 15);
        chk("b_ok_pass", 64'(b_pass), 1);
        chk("b_ok_err",  64'(b_err), 0);
        chk("b_ok_qdrain", 64'(qb_w.size() + qb_r.size()), 0);

        // rq stuck at zero: addr 0 matches, 3..15 fail, 2-bit counter saturates
        zero_b = 1'b1;
        push_b();
        run_bist(1, 15);
        zero_b = 1'b0;
        chk("b_sat_err",  64'(b_err), 3);
        chk("b_sat_fea",  64'(b_fea), 3);
        chk("b_sat_fev",  64'(b_fev), 1);
        chk("b_sat_pass", 64'(b_pass), 0);

        // start held through the run, then reset in the middle of RD0
        push_a();
        a_done_cnt = 0;
        @(negedge clk);
        a_start = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("hold_busy", 64'(a_busy), 1);
        chk("hold_rd0",  64'(a_rce), 1);
        @(negedge clk);
        rst_n   = 1'b0;
        a_start = 1'b0;
        @(posedge clk); #1;
        chk_a_reset("abort");
        @(negedge clk);
        rst_n = 1'b1;
        qa_w.delete();
        qa_r.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(a_done_cnt), 0);
        chk("abort_idle",    64'(a_busy), 0);

        push_a();
        run_bist(0, 67);
        chk("a_re_pass", 64'(a_pass), 1);
        chk("a_re_err",  64'(a_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
